// File: rtl/fpu_multiplier.sv
// IEEE-754 binary32 multiplier, one-cycle latency, round-to-nearest-even.
// Handles NaN/Inf/zero specials, subnormal inputs and gradual underflow.
module fpu_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] float1,
  input  logic [31:0] float2,
  output logic [31:0] result,
  output logic        out_valid
);

  localparam int unsigned SIG_W  = 24;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned EXP_W  = 12;
  localparam int unsigned SH_W   = 7;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                    result_sign;
  logic [7:0]              exp1_raw;
  logic [7:0]              exp2_raw;
  logic [22:0]             frac1;
  logic [22:0]             frac2;
  logic                    nan1;
  logic                    nan2;
  logic                    inf1;
  logic                    inf2;
  logic                    zero1;
  logic                    zero2;
  logic [SIG_W-1:0]        sig1;
  logic [SIG_W-1:0]        sig2;
  logic signed [EXP_W-1:0] exp1;
  logic signed [EXP_W-1:0] exp2;
  logic [PROD_W-1:0]       prod;
  logic [5:0]              lead_zeros;
  logic [PROD_W-1:0]       norm;
  logic signed [EXP_W-1:0] biased_exp;
  logic signed [EXP_W-1:0] denorm_shift;
  logic [SH_W-1:0]         shamt;
  logic [2*PROD_W-1:0]     wide;
  logic [PROD_W-1:0]       shifted;
  logic                    lost_bits;
  logic [SIG_W-1:0]        mant;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [SIG_W:0]          rounded;
  logic signed [EXP_W-1:0] rounded_exp;
  logic [22:0]             rounded_frac;
  logic [31:0]             product;

  logic [31:0]             result_d;
  logic [31:0]             result_q;
  logic                    out_valid_d;
  logic                    out_valid_q;

  // Datapath: classify, multiply, normalize, denormalize, round, pack.
  always_comb begin
    result_sign  = float1[31] ^ float2[31];
    exp1_raw     = float1[30:23];
    exp2_raw     = float2[30:23];
    frac1        = float1[22:0];
    frac2        = float2[22:0];
    nan1         = (exp1_raw == 8'hFF) && (frac1 != 23'd0);
    nan2         = (exp2_raw == 8'hFF) && (frac2 != 23'd0);
    inf1         = (exp1_raw == 8'hFF) && (frac1 == 23'd0);
    inf2         = (exp2_raw == 8'hFF) && (frac2 == 23'd0);
    zero1        = (exp1_raw == 8'h00) && (frac1 == 23'd0);
    zero2        = (exp2_raw == 8'h00) && (frac2 == 23'd0);

    sig1 = {(exp1_raw != 8'h00), frac1};
    sig2 = {(exp2_raw != 8'h00), frac2};
    exp1 = (exp1_raw == 8'h00) ? -12'sd126 : $signed({4'd0, exp1_raw}) - 12'sd127;
    exp2 = (exp2_raw == 8'h00) ? -12'sd126 : $signed({4'd0, exp2_raw}) - 12'sd127;

    prod = PROD_W'(sig1) * PROD_W'(sig2);

    lead_zeros = 6'd0;
    for (int i = 0; i < int'(PROD_W); i++) begin
      if (prod[i]) lead_zeros = 6'(int'(PROD_W) - 1 - i);
    end
    norm = prod << lead_zeros;

    // norm[47] is the hidden bit of a value in [2,4) scaled by 2^(e1+e2).
    biased_exp = exp1 + exp2 + 12'sd1 - $signed({6'd0, lead_zeros}) + 12'sd127;

    denorm_shift = 12'sd0;
    shamt        = '0;
    if (biased_exp <= 12'sd0) begin
      denorm_shift = 12'sd1 - biased_exp;
      shamt        = (denorm_shift > 12'sd48) ? SH_W'(48) : SH_W'(denorm_shift);
    end

    wide      = {norm, {PROD_W{1'b0}}} >> shamt;
    shifted   = wide[2*PROD_W-1:PROD_W];
    lost_bits = |wide[PROD_W-1:0];

    mant     = shifted[PROD_W-1:PROD_W-SIG_W];
    guard    = shifted[PROD_W-SIG_W-1];
    sticky   = (|shifted[PROD_W-SIG_W-2:0]) | lost_bits;
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + (SIG_W+1)'(round_up);

    rounded_exp  = biased_exp;
    rounded_frac = rounded[22:0];
    if (rounded[SIG_W]) begin
      rounded_exp  = biased_exp + 12'sd1;
      rounded_frac = rounded[23:1];
    end

    if (biased_exp <= 12'sd0) begin
      // Carry into bit 23 lands in the exponent LSB: smallest normal.
      product = {result_sign, 7'd0, rounded[SIG_W-1:0]};
    end else if (rounded_exp >= 12'sd255) begin
      product = {result_sign, 8'hFF, 23'd0};
    end else begin
      product = {result_sign, rounded_exp[7:0], rounded_frac};
    end

    if (nan1 || nan2) begin
      product = QNAN;
    end else if ((inf1 && zero2) || (inf2 && zero1)) begin
      product = QNAN;
    end else if (inf1 || inf2) begin
      product = {result_sign, 8'hFF, 23'd0};
    end else if (zero1 || zero2) begin
      product = {result_sign, 31'd0};
    end

    result_d    = in_valid ? product : result_q;
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fpu_multiplier.sv
// Bench for fpu_multiplier: directed vectors plus random operands checked
// against an exact integer-arithmetic rounding model.
module tb_fpu_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] float1;
  logic [31:0] float2;
  logic [31:0] result;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;

  fpu_multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .float1   (float1),
    .float2   (float2),
    .result   (result),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Product = p * 2^e exactly; pick the representable quantum, then round.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, xa, xb, e, msb, q, k, biased;
    longint fa, fb, ma, mb, p, n, rem, half;
    logic   up;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC0_0000;
    if ((ea == 255 && eb == 0 && fb == 0) || (eb == 255 && ea == 0 && fa == 0))
      return 32'h7FC0_0000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
    if ((ea == 0 && fa == 0) || (eb == 0 && fb == 0)) return {s, 31'd0};
    ma = (ea == 0) ? fa : fa + (longint'(1) << 23);
    mb = (eb == 0) ? fb : fb + (longint'(1) << 23);
    xa = (ea == 0) ? -126 : ea - 127;
    xb = (eb == 0) ? -126 : eb - 127;
    p  = ma * mb;
    e  = xa + xb - 46;
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    q = msb + e - 23;
    if (q < -149) q = -149;
    k  = q - e;
    up = 1'b0;
    if (k <= 0) begin
      n = p << (-k);
    end else if (k > 62) begin
      n = 0;
    end else begin
      n    = p >> k;
      rem  = p - (n << k);
      half = longint'(1) << (k - 1);
      up   = (rem > half) || (rem == half && n[0]);
    end
    if (up) n = n + 1;
    if (n == (longint'(1) << 24)) begin
      n = longint'(1) << 23;
      q = q + 1;
    end
    if (n < (longint'(1) << 23)) return {s, 8'd0, n[22:0]};
    biased = q + 150;
    if (biased >= 255) return {s, 8'hFF, 23'd0};
    return {s, biased[7:0], n[22:0]};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] r;
    int          kind;
    r    = $urandom;
    kind = int'($urandom_range(0, 15));
    case (kind)
      0:       r[30:0] = 31'd0;
      1:       r[30:0] = {8'hFF, 23'd0};
      2:       r[30:23] = 8'hFF;
      3, 4:    r[30:23] = 8'h00;
      5, 6, 7: r[30:23] = 8'($urandom_range(100, 154));
      8:       r[22:0]  = 23'h7FFFFF;
      default: r[30:23] = 8'($urandom_range(1, 254));
    endcase
    if (r[30:23] == 8'hFF && kind == 2 && r[22:0] == 23'd0) r[0] = 1'b1;
    return r;
  endfunction

  // Presents a pair for one edge and samples 1 ns after it.
  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    float1   = a;
    float2   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    apply(a, b);
    check_eq({tag, "_res"}, result, exp);
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  logic [31:0] ra, rb, last_exp;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    float1   = 32'h4040_0000;
    float2   = 32'h4040_0000;
    @(posedge clk);
    #1;
    check_eq("rst_res", result, 32'd0);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_vld", 32'(out_valid), 32'd0);

    run_vec("one_one",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    run_vec("two_half",  32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000);
    run_vec("neg_mul",   32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000);
    run_vec("zero_fin",  32'h0000_0000, 32'h42F6_E979, 32'h0000_0000);
    run_vec("ten_nten",  32'h4120_0000, 32'hC120_0000, 32'hC2C8_0000);
    run_vec("inf_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    run_vec("zero_ninf", 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000);
    run_vec("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_vec("ninf_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
    run_vec("overflow",  32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000);
    run_vec("min_norm_h",32'h0080_0000, 32'h3F00_0000, 32'h0040_0000);
    run_vec("min_sub_h", 32'h0000_0001, 32'h3F00_0000, 32'h0000_0000);
    run_vec("rne_up",    32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    run_vec("sub_to_nrm",32'h007F_FFFF, 32'h3F80_0001, 32'h0080_0000);
    run_vec("neg_zero",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);

    last_exp = 32'h8000_0000;
    for (int i = 0; i < 600; i++) begin
      ra = gen_operand();
      rb = gen_operand();
      last_exp = ref_mul(ra, rb);
      run_vec("rand", ra, rb, last_exp);
    end

    in_valid = 1'b0;
    float1   = 32'h4040_0000;
    float2   = 32'h4040_0000;
    @(posedge clk);
    #1;
    check_eq("hold_res", result, last_exp);
    check_eq("hold_vld", 32'(out_valid), 32'd0);

    run_vec("pre_rst", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst2_res", result, 32'd0);
    check_eq("rst2_vld", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    run_vec("post_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
